// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues SRAM-like data requests, stalls the pipeline
// while an access is in flight, checks alignment and shapes load/store data.
module mem_access_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int EN_UNALIGNED = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [5:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_rt,
  input  logic              in_exr_valid,
  input  logic [5:0]        in_exr_type,
  input  logic [ADDR_W-1:0] in_badvaddr,
  input  logic              flush,
  output logic              stall_req,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              out_exr_valid,
  output logic [5:0]        out_exr_type,
  output logic [ADDR_W-1:0] out_badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [1:0]        n_c;
  logic [4:0]        sh_lo_c;
  logic [4:0]        sh_hi_c;
  logic              is_mem_c, is_store_c, is_lr_c, ade_l_c, ade_s_c;
  logic [1:0]        size_c;
  logic [3:0]        wstrb_c;
  logic [31:0]       wdata_c;
  logic              exc_c, vin_c, launch_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic [31:0]       load_c;

  logic              wr_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        wstrb_reg;
  logic [31:0]       wdata_reg;
  logic [5:0]        op_reg;
  logic [1:0]        n_reg;
  logic [31:0]       rt_reg;
  logic [31:0]       rdata_reg;
  logic              discard_reg;

  assign n_c     = in_addr[1:0];
  assign sh_lo_c = {n_c, 3'b000};
  assign sh_hi_c = {2'd3 - n_c, 3'b000};

  always_comb begin
    is_mem_c   = 1'b0;
    is_store_c = 1'b0;
    is_lr_c    = 1'b0;
    ade_l_c    = 1'b0;
    ade_s_c    = 1'b0;
    size_c     = 2'd0;
    wstrb_c    = 4'b0000;
    wdata_c    = 32'h0;
    case (in_op)
      OP_LB, OP_LBU: begin
        is_mem_c = 1'b1;
        wstrb_c  = 4'b0001 << n_c;
      end
      OP_LH, OP_LHU: begin
        is_mem_c = 1'b1;
        size_c   = 2'd1;
        wstrb_c  = 4'b0011 << n_c;
        ade_l_c  = in_addr[0];
      end
      OP_LW: begin
        is_mem_c = 1'b1;
        size_c   = 2'd2;
        wstrb_c  = 4'b1111;
        ade_l_c  = |n_c;
      end
      OP_SB: begin
        is_mem_c   = 1'b1;
        is_store_c = 1'b1;
        wstrb_c    = 4'b0001 << n_c;
        wdata_c    = {4{in_rt[7:0]}};
      end
      OP_SH: begin
        is_mem_c   = 1'b1;
        is_store_c = 1'b1;
        size_c     = 2'd1;
        wstrb_c    = 4'b0011 << n_c;
        wdata_c    = {2{in_rt[15:0]}};
        ade_s_c    = in_addr[0];
      end
      OP_SW: begin
        is_mem_c   = 1'b1;
        is_store_c = 1'b1;
        size_c     = 2'd2;
        wstrb_c    = 4'b1111;
        wdata_c    = in_rt;
        ade_s_c    = |n_c;
      end
      OP_LWL, OP_SWL: begin
        if (EN_UNALIGNED != 0) begin
          is_mem_c   = 1'b1;
          is_lr_c    = 1'b1;
          is_store_c = (in_op == OP_SWL);
          size_c     = 2'd2;
          wstrb_c    = 4'b1111 >> (2'd3 - n_c);
          wdata_c    = (in_op == OP_SWL) ? (in_rt >> sh_hi_c) : 32'h0;
        end
      end
      OP_LWR, OP_SWR: begin
        if (EN_UNALIGNED != 0) begin
          is_mem_c   = 1'b1;
          is_lr_c    = 1'b1;
          is_store_c = (in_op == OP_SWR);
          size_c     = 2'd2;
          wstrb_c    = 4'b1111 << n_c;
          wdata_c    = (in_op == OP_SWR) ? (in_rt << sh_lo_c) : 32'h0;
        end
      end
      default: ;
    endcase
  end

  // Gating with resetn keeps data_req/out_valid low while reset is held.
  assign vin_c      = in_valid & resetn;
  assign exc_c      = in_exr_valid | ade_l_c | ade_s_c;
  assign launch_c   = (state_reg == S_IDLE) & vin_c & is_mem_c & ~exc_c & ~flush;
  assign req_addr_c = is_lr_c ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;

  // Load shaping works off the captured op/offset/rt since in_* may not be trusted later.
  always_comb begin
    load_c = 32'h0;
    case (op_reg)
      OP_LB:  load_c = {{24{data_rdata[{n_reg, 3'b000} + 7]}}, data_rdata[{n_reg, 3'b000} +: 8]};
      OP_LBU: load_c = {24'h0, data_rdata[{n_reg, 3'b000} +: 8]};
      OP_LH:  load_c = {{16{data_rdata[{n_reg[1], 4'b0000} + 15]}}, data_rdata[{n_reg[1], 4'b0000} +: 16]};
      OP_LHU: load_c = {16'h0, data_rdata[{n_reg[1], 4'b0000} +: 16]};
      OP_LW:  load_c = data_rdata;
      OP_LWL: load_c = (data_rdata << {2'd3 - n_reg, 3'b000}) |
                       (rt_reg & (32'h00FF_FFFF >> {n_reg, 3'b000}));
      OP_LWR: load_c = (data_rdata >> {n_reg, 3'b000}) |
                       (rt_reg & ~(32'hFFFF_FFFF >> {n_reg, 3'b000}));
      default: load_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (launch_c) state_next = data_addr_ok ? S_WAIT : S_REQ;
      S_REQ:  if (data_addr_ok) state_next = S_WAIT;
      S_WAIT: if (data_data_ok) state_next = (discard_reg | flush) ? S_IDLE : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_reg      <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= '0;
      wstrb_reg   <= 4'b0000;
      wdata_reg   <= 32'h0;
      op_reg      <= 6'h0;
      n_reg       <= 2'd0;
      rt_reg      <= 32'h0;
      rdata_reg   <= 32'h0;
      discard_reg <= 1'b0;
    end else begin
      if (launch_c) begin
        wr_reg    <= is_store_c;
        size_reg  <= size_c;
        addr_reg  <= req_addr_c;
        wstrb_reg <= wstrb_c;
        wdata_reg <= wdata_c;
        op_reg    <= in_op;
        n_reg     <= n_c;
        rt_reg    <= in_rt;
      end
      if (state_reg == S_WAIT && data_data_ok) begin
        rdata_reg   <= load_c;
        discard_reg <= 1'b0;
      end else if ((state_reg == S_REQ || state_reg == S_WAIT) && flush) begin
        discard_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    stall_req     = 1'b0;
    out_valid     = 1'b0;
    out_rdata     = 32'h0;
    out_exr_valid = 1'b0;
    out_exr_type  = 6'h0;
    out_badvaddr  = '0;
    data_req      = 1'b0;
    data_wr       = wr_reg;
    data_size     = size_reg;
    data_addr     = addr_reg;
    data_wstrb    = wstrb_reg;
    data_wdata    = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        stall_req     = launch_c;
        data_req      = launch_c;
        data_wr       = is_store_c;
        data_size     = size_c;
        data_addr     = req_addr_c;
        data_wstrb    = wstrb_c;
        data_wdata    = wdata_c;
        out_valid     = vin_c & ~flush & ~launch_c;
        out_exr_valid = vin_c & ~flush & exc_c;
        if (vin_c & ~flush & exc_c) begin
          out_exr_type = in_exr_valid ? in_exr_type : (ade_s_c ? 6'h05 : 6'h04);
          out_badvaddr = in_exr_valid ? in_badvaddr : in_addr;
        end
      end
      S_REQ: begin
        stall_req = 1'b1;
        data_req  = 1'b1;
      end
      S_WAIT: stall_req = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        out_rdata = rdata_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single transactions plus
// hand-written latency, flush and reset sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_exr_valid, flush;
  logic [5:0]  in_op, in_exr_type;
  logic [31:0] in_addr, in_rt, in_badvaddr;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic        stall_req, out_valid, out_exr_valid, data_req, data_wr;
  logic [31:0] out_rdata, out_badvaddr, data_addr, data_wdata;
  logic [5:0]  out_exr_type;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  logic        d0_stall_req, d0_out_valid, d0_out_exr_valid, d0_data_req, d0_data_wr;
  logic [31:0] d0_out_rdata, d0_out_badvaddr, d0_data_addr, d0_data_wdata;
  logic [5:0]  d0_out_exr_type;
  logic [1:0]  d0_data_size;
  logic [3:0]  d0_data_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .EN_UNALIGNED(1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_rt(in_rt), .in_exr_valid(in_exr_valid), .in_exr_type(in_exr_type),
    .in_badvaddr(in_badvaddr), .flush(flush), .stall_req(stall_req), .out_valid(out_valid),
    .out_rdata(out_rdata), .out_exr_valid(out_exr_valid), .out_exr_type(out_exr_type),
    .out_badvaddr(out_badvaddr), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  mem_access_ctrl #(.ADDR_W(32), .EN_UNALIGNED(0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_rt(in_rt), .in_exr_valid(in_exr_valid), .in_exr_type(in_exr_type),
    .in_badvaddr(in_badvaddr), .flush(flush), .stall_req(d0_stall_req),
    .out_valid(d0_out_valid), .out_rdata(d0_out_rdata), .out_exr_valid(d0_out_exr_valid),
    .out_exr_type(d0_out_exr_type), .out_badvaddr(d0_out_badvaddr), .data_req(d0_data_req),
    .data_wr(d0_data_wr), .data_size(d0_data_size), .data_addr(d0_data_addr),
    .data_wstrb(d0_data_wstrb), .data_wdata(d0_data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        exr;
    logic [5:0]  exr_type;
    logic [31:0] badv_in;
    logic        fl;
    logic [31:0] rdata;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] daddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        valid0;
    logic        exr_o;
    logic [5:0]  type_o;
    logic [31:0] badv_o;
    logic [31:0] rdata_o;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = 6'h0; in_addr = 32'h0; in_rt = 32'h0;
    in_exr_valid = 1'b0; in_exr_type = 6'h0; in_badvaddr = 32'h0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic is_lr;
    is_lr = (v.op == 6'h22) || (v.op == 6'h26) || (v.op == 6'h2A) || (v.op == 6'h2E);
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_rt = v.rt;
    in_exr_valid = v.exr; in_exr_type = v.exr_type; in_badvaddr = v.badv_in; flush = v.fl;
    data_addr_ok = v.req; data_data_ok = 1'b0;
    #1;
    chk("req", data_req, v.req);
    chk("stall0", stall_req, v.req);
    chk("valid0", out_valid, v.valid0);
    chk("exr_valid", out_exr_valid, v.exr_o);
    if (v.exr_o) begin
      chk("exr_type", out_exr_type, v.type_o);
      chk("badvaddr", out_badvaddr, v.badv_o);
    end
    if (is_lr) begin
      chk("d0_req", d0_data_req, 1'b0);
      chk("d0_valid", d0_out_valid, 1'b1);
    end else begin
      chk("d0_req", d0_data_req, v.req);
    end
    if (v.req) begin
      chk("wr", data_wr, v.wr);
      chk("size", data_size, v.size);
      chk("daddr", data_addr, v.daddr);
      chk("wstrb", data_wstrb, v.wstrb);
      chk("wdata", data_wdata, v.wdata);
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
      #1;
      chk("stall_wait", stall_req, 1'b1);
      chk("valid_wait", out_valid, 1'b0);
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk("valid_done", out_valid, 1'b1);
      chk("rdata_done", out_rdata, v.rdata_o);
      chk("stall_done", stall_req, 1'b0);
      chk("norelaunch", data_req, 1'b0);
    end else if (v.valid0) begin
      chk("rdata_nomem", out_rdata, 32'h0);
    end
    $display("vec %0d op=%h addr=%h req=%0d valid0=%0d exr=%0d rdata=%h",
             idx, v.op, v.addr, data_req, out_valid, out_exr_valid, out_rdata);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("stall_idle", stall_req, 1'b0);
  endtask

  initial begin
    int first_valid;
    int stall_cnt;
    logic [31:0] got_rdata;

    //       op     addr          rt            ex  type   badv_in       fl  rdata         req wr sz  daddr         strb     wdata         v0  exo tyo    badv_o        rdata_o
    vecs[0]  = '{6'h20, 32'h0000_1003, 32'h0,         0, 6'h00, 32'h0,         0, 32'h8012_3456, 1, 0, 2'd0, 32'h0000_1003, 4'b1000, 32'h0,         0, 0, 6'h00, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{6'h24, 32'h0000_1003, 32'h0,         0, 6'h00, 32'h0,         0, 32'h8012_3456, 1, 0, 2'd0, 32'h0000_1003, 4'b1000, 32'h0,         0, 0, 6'h00, 32'h0,         32'h0000_0080};
    vecs[2]  = '{6'h21, 32'h0000_1002, 32'h0,         0, 6'h00, 32'h0,         0, 32'h8001_7FFF, 1, 0, 2'd1, 32'h0000_1002, 4'b1100, 32'h0,         0, 0, 6'h00, 32'h0,         32'hFFFF_8001};
    vecs[3]  = '{6'h25, 32'h0000_1000, 32'h0,         0, 6'h00, 32'h0,         0, 32'h8001_7FFF, 1, 0, 2'd1, 32'h0000_1000, 4'b0011, 32'h0,         0, 0, 6'h00, 32'h0,         32'h0000_7FFF};
    vecs[4]  = '{6'h29, 32'h0000_2002, 32'h1234_ABCD, 0, 6'h00, 32'h0,         0, 32'h0,         1, 1, 2'd1, 32'h0000_2002, 4'b1100, 32'hABCD_ABCD, 0, 0, 6'h00, 32'h0,         32'h0};
    vecs[5]  = '{6'h28, 32'h0000_2001, 32'h0000_00A5, 0, 6'h00, 32'h0,         0, 32'h0,         1, 1, 2'd0, 32'h0000_2001, 4'b0010, 32'hA5A5_A5A5, 0, 0, 6'h00, 32'h0,         32'h0};
    vecs[6]  = '{6'h2B, 32'h0000_2004, 32'hDEAD_BEEF, 0, 6'h00, 32'h0,         0, 32'h0,         1, 1, 2'd2, 32'h0000_2004, 4'b1111, 32'hDEAD_BEEF, 0, 0, 6'h00, 32'h0,         32'h0};
    vecs[7]  = '{6'h29, 32'h0000_2001, 32'h1234_ABCD, 0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h05, 32'h0000_2001, 32'h0};
    vecs[8]  = '{6'h23, 32'h0000_1002, 32'h0,         0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h04, 32'h0000_1002, 32'h0};
    vecs[9]  = '{6'h25, 32'h0000_1001, 32'h0,         0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h04, 32'h0000_1001, 32'h0};
    vecs[10] = '{6'h23, 32'h0000_0003, 32'h0,         1, 6'h0A, 32'h0BAD_0000, 0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h0A, 32'h0BAD_0000, 32'h0};
    vecs[11] = '{6'h22, 32'h0000_1001, 32'h1122_3344, 0, 6'h00, 32'h0,         0, 32'hAABB_CCDD, 1, 0, 2'd2, 32'h0000_1000, 4'b0011, 32'h0,         0, 0, 6'h00, 32'h0,         32'hCCDD_3344};
    vecs[12] = '{6'h26, 32'h0000_1001, 32'h1122_3344, 0, 6'h00, 32'h0,         0, 32'hAABB_CCDD, 1, 0, 2'd2, 32'h0000_1000, 4'b1110, 32'h0,         0, 0, 6'h00, 32'h0,         32'h11AA_BBCC};
    vecs[13] = '{6'h2A, 32'h0000_1001, 32'h1122_3344, 0, 6'h00, 32'h0,         0, 32'h0,         1, 1, 2'd2, 32'h0000_1000, 4'b0011, 32'h0000_1122, 0, 0, 6'h00, 32'h0,         32'h0};
    vecs[14] = '{6'h2E, 32'h0000_1002, 32'h1122_3344, 0, 6'h00, 32'h0,         0, 32'h0,         1, 1, 2'd2, 32'h0000_1000, 4'b1100, 32'h3344_0000, 0, 0, 6'h00, 32'h0,         32'h0};
    vecs[15] = '{6'h22, 32'h0000_1003, 32'h1122_3344, 0, 6'h00, 32'h0,         0, 32'hAABB_CCDD, 1, 0, 2'd2, 32'h0000_1000, 4'b1111, 32'h0,         0, 0, 6'h00, 32'h0,         32'hAABB_CCDD};
    vecs[16] = '{6'h00, 32'h0000_0000, 32'h0,         0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 0, 6'h00, 32'h0,         32'h0};
    vecs[17] = '{6'h23, 32'h0000_1000, 32'h0,         0, 6'h00, 32'h0,         1, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         0, 0, 6'h00, 32'h0,         32'h0};
    vecs[18] = '{6'h23, 32'h0000_1000, 32'h0,         0, 6'h00, 32'h0,         0, 32'h1234_5678, 1, 0, 2'd2, 32'h0000_1000, 4'b1111, 32'h0,         0, 0, 6'h00, 32'h0,         32'h1234_5678};
    vecs[19] = '{6'h2B, 32'h0000_2003, 32'h0,         0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h05, 32'h0000_2003, 32'h0};
    vecs[20] = '{6'h21, 32'h0000_1003, 32'h0,         0, 6'h00, 32'h0,         0, 32'h0,         0, 0, 2'd0, 32'h0,         4'b0000, 32'h0,         1, 1, 6'h04, 32'h0000_1003, 32'h0};

    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_exr", out_exr_valid, 1'b0);
    $display("reset: req=%0d stall=%0d valid=%0d", data_req, stall_req, out_valid);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // LW with addr_ok after two waits and data_ok three cycles after acceptance.
    first_valid = -1;
    stall_cnt = 0;
    got_rdata = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = (c < 7); in_op = 6'h23; in_addr = 32'h0000_1000;
      data_addr_ok = (c == 2);
      data_data_ok = (c == 1) || (c == 5);
      data_rdata = (c == 5) ? 32'h8080_F00F : 32'hDEAD_0000;
      #1;
      if (stall_req) stall_cnt++;
      if (out_valid && first_valid < 0) begin
        first_valid = c;
        got_rdata = out_rdata;
      end
      if (c == 1 || c == 2) begin
        chk("long_req_held", data_req, 1'b1);
        chk("long_req_addr", data_addr, 32'h0000_1000);
      end
    end
    chk("long_stall_cycles", stall_cnt, 6);
    chk("long_valid_cycle", first_valid, 6);
    chk("long_rdata", got_rdata, 32'h8080_F00F);
    $display("long LW: stall=%0d valid_cycle=%0d rdata=%h", stall_cnt, first_valid, got_rdata);
    @(negedge clk);
    idle_inputs();

    // Flush while WAIT: result discarded, FSM back in IDLE able to launch again.
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h0000_1000; data_addr_ok = 1'b1;
    #1;
    chk("fl_launch", data_req, 1'b1);
    @(negedge clk);
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fl_wait_stall", stall_req, 1'b1);
    chk("fl_wait_valid", out_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    chk("fl_dataok_valid", out_valid, 1'b0);
    chk("fl_dataok_stall", stall_req, 1'b1);
    @(negedge clk);
    data_data_ok = 1'b0;
    in_valid = 1'b1; in_op = 6'h23; in_addr = 32'h0000_1004; data_addr_ok = 1'b1;
    #1;
    chk("fl_after_valid", out_valid, 1'b0);
    chk("fl_after_relaunch", data_req, 1'b1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0A0B_0C0D;
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("fl_next_valid", out_valid, 1'b1);
    chk("fl_next_rdata", out_rdata, 32'h0A0B_0C0D);
    $display("flush in WAIT: next rdata=%h valid=%0d", out_rdata, out_valid);
    @(negedge clk);
    idle_inputs();

    // Reset in the middle of a request aborts it at once.
    @(negedge clk);
    in_valid = 1'b1; in_op = 6'h2B; in_addr = 32'h0000_3000; in_rt = 32'h0000_0001;
    @(negedge clk);
    #1;
    chk("mid_req", data_req, 1'b1);
    chk("mid_stall", stall_req, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_req", data_req, 1'b0);
    chk("mid_rst_stall", stall_req, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_req", data_req, 1'b0);
    chk("post_rst_stall", stall_req, 1'b0);
    $display("mid-transaction reset: req=%0d stall=%0d", data_req, stall_req);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
